// File: rtl/seq_tx.sv
//==============================================================================
// Module      : seq_tx
// Description : Serial pattern transmitter. Accepts a parallel word over a
//               load/ready handshake and shifts it out MSB-first on dout,
//               one bit per clock, followed by GAP idle cycles (dout=1).
//               Optional build macro SEQ_TX_PREAMBLE_EN prepends the sync
//               preamble 0101_0101 to every frame.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_tx #(
   parameter int WIDTH = 8,   // payload bits per frame, 2..32
   parameter int GAP   = 2    // idle cycles after the last payload bit, 0..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   output logic             ready,
   output logic             dout,
   output logic             busy,
   output logic             done
);

   // Bit counter must hold both WIDTH-1 and the 7 used by the preamble.
   localparam int CW = $clog2((WIDTH > 8) ? WIDTH : 8);

`ifdef SEQ_TX_PREAMBLE_EN
   localparam logic [7:0] PRE_PATTERN = 8'b0101_0101;  // sent bit 7 first
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [3:0]       gcnt, gcnt_n;
   logic             dout_n, ready_n, busy_n, done_n;

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         sreg  <= '0;
         cnt   <= '0;
         gcnt  <= '0;
         dout  <= 1'b1;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         sreg  <= sreg_n;
         cnt   <= cnt_n;
         gcnt  <= gcnt_n;
         dout  <= dout_n;
         ready <= ready_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   // Next-state and next-output logic. dout_n is the bit the line will carry
   // in the following cycle, so the first bit appears one cycle after accept.
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
      gcnt_n  = gcnt;
      dout_n  = 1'b1;
      done_n  = 1'b0;

      case (state)
         S_IDLE: begin
            if (load && ready) begin
`ifdef SEQ_TX_PREAMBLE_EN
               state_n = S_PRE;
               sreg_n  = data;
               cnt_n   = CW'(7);
               dout_n  = PRE_PATTERN[7];
`else
               state_n = S_DATA;
               sreg_n  = {data[WIDTH-2:0], 1'b0};
               cnt_n   = CW'(WIDTH - 1);
               dout_n  = data[WIDTH-1];
`endif
            end
         end

`ifdef SEQ_TX_PREAMBLE_EN
         S_PRE: begin
            if (cnt == '0) begin
               // Last preamble bit on the line; queue the payload MSB.
               state_n = S_DATA;
               dout_n  = sreg[WIDTH-1];
               sreg_n  = {sreg[WIDTH-2:0], 1'b0};
               cnt_n   = CW'(WIDTH - 1);
            end else begin
               dout_n  = PRE_PATTERN[3'(cnt - CW'(1))];
               cnt_n   = cnt - CW'(1);
            end
         end
`endif

         S_DATA: begin
            if (cnt == '0) begin
               // Last payload bit on the line; done rides with the next cycle.
               done_n = 1'b1;
               if (GAP > 0) begin
                  state_n = S_GAP;
                  gcnt_n  = 4'(GAP - 1);
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               dout_n = sreg[WIDTH-1];
               sreg_n = {sreg[WIDTH-2:0], 1'b0};
               cnt_n  = cnt - CW'(1);
            end
         end

         S_GAP: begin
            if (gcnt == '0) begin
               state_n = S_IDLE;
            end else begin
               gcnt_n = gcnt - 4'd1;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      ready_n = (state_n == S_IDLE);
      busy_n  = !ready_n;
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_tx.sv
//==============================================================================
// Module      : tb_seq_tx
// Description : Self-checking bench for seq_tx. Unit 0 uses GAP=2, unit 1
//               uses GAP=0. Expected per-cycle {dout,done,ready} triplets are
//               queued when a frame is requested and popped once per cycle.
//               Honours SEQ_TX_PREAMBLE_EN when the build defines it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_tx;

`ifdef SEQ_TX_PREAMBLE_EN
   localparam int P = 8;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] load_v;
   logic [7:0] data_v [2];
   logic [1:0] ready_v, dout_v, busy_v, done_v;

   logic [2:0] exp_q [$];   // {dout, done, ready} per cycle
   int         checks = 0;
   int         errors = 0;
   int         n_done = 0;
   int         cyc    = 0;

   seq_tx #(.WIDTH(8), .GAP(2)) u_gap2 (
      .clk(clk), .rst_n(rst_n), .data(data_v[0]), .load(load_v[0]),
      .ready(ready_v[0]), .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   seq_tx #(.WIDTH(8), .GAP(0)) u_gap0 (
      .clk(clk), .rst_n(rst_n), .data(data_v[1]), .load(load_v[1]),
      .ready(ready_v[1]), .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard stop in case anything stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int u, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s unit=%0d cycle=%0d observed=%b expected=%b", tag, u, cyc, obs, exp);
      end
   endtask

   // Queue the line behaviour of one frame: preamble, payload, gap, idle.
   task automatic push_frame(input logic [7:0] d, input int gap);
      for (int i = 0; i < P; i++) exp_q.push_back({i[0], 2'b00});
      for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 2'b00});
      for (int g = 1; g <= gap; g++) exp_q.push_back({1'b1, (g == 1), 1'b0});
      exp_q.push_back({1'b1, (gap == 0), 1'b1});
   endtask

   // Advance one cycle and compare unit u against the next queued entry.
   task automatic tick(input int u);
      logic [2:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (done_v[u]) n_done++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("dout",  u, dout_v[u],  e[2]);
         chk("done",  u, done_v[u],  e[1]);
         chk("ready", u, ready_v[u], e[0]);
         chk("busy",  u, busy_v[u],  !e[0]);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      load_v    = 2'b11;
      data_v[0] = 8'hFF;
      data_v[1] = 8'hFF;

      // Reset held for three edges with load asserted.
      repeat (3) begin
         @(posedge clk);
         #1;
         cyc++;
         for (int u = 0; u < 2; u++) begin
            chk("rst_dout",  u, dout_v[u],  1'b1);
            chk("rst_ready", u, ready_v[u], 1'b1);
            chk("rst_busy",  u, busy_v[u],  1'b0);
            chk("rst_done",  u, done_v[u],  1'b0);
         end
      end
      rst_n  = 1'b1;
      load_v = 2'b00;
      exp_q.push_back(3'b101);
      tick(0);

      // Single frame A5 on the GAP=2 unit.
      data_v[0] = 8'hA5;
      load_v[0] = 1'b1;
      push_frame(8'hA5, 2);
      tick(0);
      load_v[0] = 1'b0;
      while (exp_q.size() > 0) tick(0);

      // Ignored requests during DATA and GAP; data changed after accept.
      data_v[0] = 8'h96;
      load_v[0] = 1'b1;
      push_frame(8'h96, 2);
      tick(0);
      data_v[0] = 8'h00;
      for (int c = 1; exp_q.size() > 0; c++) begin
         load_v[0] = (c == 4 || c == P + 9 || c == P + 10);
         tick(0);
      end
      load_v[0] = 1'b0;
      repeat (3) exp_q.push_back(3'b101);
      while (exp_q.size() > 0) tick(0);

      // Back-to-back frames with GAP=0 and load held high.
      n_done    = 0;
      data_v[1] = 8'hF0;
      load_v[1] = 1'b1;
      push_frame(8'hF0, 0);
      push_frame(8'h0F, 0);
      tick(1);
      data_v[1] = 8'h0F;
      for (int c = 1; exp_q.size() > 0; c++) begin
         load_v[1] = (c < P + 10);
         tick(1);
      end
      load_v[1] = 1'b0;
      repeat (2) exp_q.push_back(3'b101);
      while (exp_q.size() > 0) tick(1);
      checks++;
      assert (n_done == 2) else begin
         errors++;
         $error("FAIL done_count unit=1 observed=%0d expected=2", n_done);
      end

      // Abort with reset on the 4th payload bit of 3C.
      n_done    = 0;
      data_v[0] = 8'h3C;
      load_v[0] = 1'b1;
      push_frame(8'h3C, 2);
      tick(0);
      load_v[0] = 1'b0;
      for (int c = 1; c < P + 4; c++) tick(0);
      rst_n = 1'b0;
      exp_q.delete();
      exp_q.push_back(3'b101);
      tick(0);
      rst_n = 1'b1;
      exp_q.push_back(3'b101);
      tick(0);
      checks++;
      assert (n_done == 0) else begin
         errors++;
         $error("FAIL abort_done unit=0 observed=%0d expected=0", n_done);
      end

      // Fresh frame after the abort.
      data_v[0] = 8'h81;
      load_v[0] = 1'b1;
      push_frame(8'h81, 2);
      tick(0);
      load_v[0] = 1'b0;
      while (exp_q.size() > 0) tick(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter: accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single-bit line, one bit per clock, with a fixed idle gap between frames. It is the sending end of the serial bit line consumed by the team's Moore sequence detectors, whose `din` it drives in the lab bench. An optional 8-bit sync preamble (`0101_0101`) ahead of each frame makes the downstream detector flag once at the start of every frame.

## Interface
- `WIDTH`, default 8: payload bits per frame; legal range 2..32.
- `GAP`, default 2: idle cycles (`dout`=1) after the last payload bit before `ready` returns; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `data`  in  WIDTH  payload word; sampled only on the accepting edge.
- `load`  in  1  request to send `data`.
- `ready`  out  1  high only in IDLE; the handshake is `load && ready` at a rising edge.
- `dout`  out  1  serial line, registered; idles at 1.
- `busy`  out  1  high in PRE, DATA and GAP.
- `done`  out  1  one-cycle pulse after the last payload bit.

## Operation
- Reset (`rst_n`=0 at an edge): state=IDLE, `dout`=1, `ready`=1, `busy`=0, `done`=0, shift register and counters cleared. Reset mid-frame aborts the frame. No partial bits are emitted after the reset edge.
- States: IDLE, PRE (only with the macro), DATA, GAP.
- IDLE: `dout`=1. On `load && ready`, capture `data` into the shift register and load the bit counter:
  - with the macro, go to PRE with the counter at 7;
  - without it, go to DATA with the counter at WIDTH-1.
- PRE: `dout` = preamble bit, sent first-to-last as 0,1,0,1,0,1,0,1. After 8 cycles, go to DATA with the counter at WIDTH-1.
- DATA: `dout` = shift-register MSB, then shift left; decrement the counter.
  - After the WIDTH-th bit, go to GAP if GAP>0, else IDLE.
  - `done` pulses in the cycle immediately after the last bit.
- GAP: `dout`=1 for exactly GAP cycles, then IDLE.
- `load` while not in IDLE is ignored and not queued. Changes to `data` after the accept edge have no effect.
- Counter width: $clog2(max(WIDTH,8)) bits. The counter never wraps below 0, because the state changes at 0.
- Default case: any illegal state encoding returns to IDLE with `dout`=1.

## Timing
- Latency: the first transmitted bit appears on `dout` in the cycle after the accept edge.
- Frame period, accept edge to the next possible accept edge: (8 if preamble) + WIDTH + GAP + 1 cycles.
  - WIDTH=8, GAP=2: 11 cycles without the preamble, 19 with it.
- `ready` falls on the accept edge and rises on the edge that enters IDLE.
- `done` coincides with the first GAP cycle. With GAP=0, it coincides with the IDLE cycle in which `ready`=1, so back-to-back frames are legal.
- `busy` = !`ready` whenever `rst_n`=1.
- All outputs are registered; no combinational path from `load` or `data` to any output.

## Configuration
- `SEQ_TX_PREAMBLE_EN` defined: the PRE state exists and every frame is preceded by `0101_0101`. The latency to the first payload bit becomes 9 cycles after the accept edge.
- Not defined: the PRE state and the preamble logic are absent. The payload starts 1 cycle after the accept edge.
- Ports and parameters are identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 3 edges with `load`=1 → `dout`=1, `ready`=1, `busy`=0, `done`=0 throughout. No frame starts until the first edge with `rst_n`=1.
- Single frame, no macro, WIDTH=8, GAP=2, `data`=8'hA5 → `dout` = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept. Then:
  - `done`=1 on cycle 9 only;
  - `dout`=1 on cycles 9..10;
  - `ready`=1 on cycle 11.
- Back-to-back frames, GAP=0, `load` held high, `data`=8'hF0 then 8'h0F → 16 contiguous payload bits `11110000_00001111` separated by exactly one IDLE cycle. Exactly two `done` pulses.
- Preamble build with the macro defined, `data`=8'hFF, `dout` wired to the Moore detector's `din` → `dout` = 0,1,0,1,0,1,0,1,1×8. The detector `flag` is high for exactly one cycle per frame.
- Abort: deassert `rst_n` on the 4th payload bit of 8'h3C → the next edge gives `dout`=1 and `ready`=1, with no `done` pulse. A new `load` of 8'h81 then transmits all 8 bits correctly.
- Ignored requests: pulse `load` with `data`=8'h00 during DATA and during GAP → no effect on the current frame and no second frame.
